// File: rtl/bridge_reset_pkg.sv
// Shared definitions for the DE5 bridge reset/bring-up sequencer:
// state encoding and the per-state reset/status output decode.
package bridge_reset_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_I2C  = 3'd1,
    ST_PHY_RST   = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_WAIT_LINK = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic phy_reset;
    logic soc_reset;
    logic mac_reset;
    logic seq_ready;
    logic seq_error;
  } seq_outs_t;

  // FAIL keeps the SoC out of reset so the host can still reach the board.
  function automatic seq_outs_t decode_outs(input seq_state_e st);
    seq_outs_t o;
    o.phy_reset = (st == ST_HOLD) || (st == ST_WAIT_I2C) ||
                  (st == ST_PHY_RST) || (st == ST_FAIL);
    o.soc_reset = (st == ST_HOLD);
    o.mac_reset = (st != ST_RUN);
    o.seq_ready = (st == ST_RUN);
    o.seq_error = (st == ST_FAIL);
    return o;
  endfunction

endpackage

// File: rtl/bridge_reset_seq_sync2.sv
// Parameterized-width two-flop synchronizer, asynchronously reset to 0.
module sync2
  import bridge_reset_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking assignments keep the two stages as distinct flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/bridge_reset_seq.sv
// Reset/bring-up sequencer: orders SoC, PHY and MAC reset release behind
// Si570 init, PLL lock and lane tx_ready, with timeout and bounded retry.
module bridge_reset_seq
  import bridge_reset_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int HOLD_CYCLES    = 1024,
  parameter int PHY_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int RETRY_LIMIT    = 3
) (
  input  logic                   clk_50mhz,
  input  logic                   rst_50mhz,
  input  logic                   soft_reset_req,
  input  logic                   i2c_init_busy,
  input  logic                   phy_pll_locked,
  input  logic [NUM_LANES-1:0]   phy_tx_ready,
  input  logic [NUM_LANES-1:0]   phy_rx_ready,
  output logic                   phy_reset,
  output logic                   soc_reset,
  output logic                   mac_reset,
  output logic                   seq_ready,
  output logic                   seq_error,
  output logic [SEQ_STATE_W-1:0] seq_state,
  output logic [NUM_LANES-1:0]   link_up,
  output logic [1:0]             retry_count
);

  localparam int CNT_MAX_A = (HOLD_CYCLES > PHY_RST_CYCLES) ? HOLD_CYCLES : PHY_RST_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam int SYNC_W = 2 * NUM_LANES + 1;

  seq_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [1:0]        r_retry, w_retry_next, w_retry_inc;
  logic              w_timeout, w_cnt_run;
  seq_outs_t         r_outs, w_outs_next;
  logic [SYNC_W-1:0] w_sync;
  logic              w_pll;
  logic [NUM_LANES-1:0] w_tx;

  sync2 #(.WIDTH(SYNC_W)) u_sync (
    .clk (clk_50mhz),
    .rst (rst_50mhz),
    .i_d ({phy_pll_locked, phy_tx_ready, phy_rx_ready}),
    .o_q (w_sync)
  );

  assign w_pll   = w_sync[SYNC_W-1];
  assign w_tx    = w_sync[SYNC_W-2 -: NUM_LANES];
  assign link_up = w_sync[NUM_LANES-1:0];

  assign w_retry_inc = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_timeout    = 1'b0;
    w_cnt_run    = 1'b0;
    if (soft_reset_req) begin
      w_state_next = ST_HOLD;
      w_retry_next = 2'd0;
    end else begin
      unique case (r_state)
        ST_HOLD:      if (r_cnt == HOLD_LAST) w_state_next = ST_WAIT_I2C;
                      else w_cnt_run = 1'b1;
        ST_WAIT_I2C:  if (!i2c_init_busy) w_state_next = ST_PHY_RST;
        ST_PHY_RST:   if (r_cnt == PRST_LAST) w_state_next = ST_WAIT_LOCK;
                      else w_cnt_run = 1'b1;
        ST_WAIT_LOCK: if (w_pll) w_state_next = ST_WAIT_LINK;
                      else if (r_cnt == LOCK_LAST) w_timeout = 1'b1;
                      else w_cnt_run = 1'b1;
        ST_WAIT_LINK: if (!w_pll) w_state_next = ST_PHY_RST;
                      else if (&w_tx) w_state_next = ST_RUN;
                      else if (r_cnt == LOCK_LAST) w_timeout = 1'b1;
                      else w_cnt_run = 1'b1;
        ST_RUN:       if (!w_pll) w_state_next = ST_PHY_RST;
        ST_FAIL:      w_state_next = ST_FAIL;
        default:      w_state_next = ST_HOLD;
      endcase
    end
    if (w_timeout) begin
      w_retry_next = w_retry_inc;
      w_state_next = (int'(w_retry_inc) == RETRY_LIMIT) ? ST_FAIL : ST_PHY_RST;
    end
    // The shared counter measures time spent in the current state only.
    if (soft_reset_req || (w_state_next != r_state)) w_cnt_next = '0;
    else if (w_cnt_run)                              w_cnt_next = r_cnt + 1'b1;
    else                                             w_cnt_next = r_cnt;
    w_outs_next = decode_outs(w_state_next);
  end

  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_retry <= 2'd0;
      r_outs  <= decode_outs(ST_HOLD);
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_retry <= w_retry_next;
      r_outs  <= w_outs_next;
    end
  end

  assign phy_reset   = r_outs.phy_reset;
  assign soc_reset   = r_outs.soc_reset;
  assign mac_reset   = r_outs.mac_reset;
  assign seq_ready   = r_outs.seq_ready;
  assign seq_error   = r_outs.seq_error;
  assign seq_state   = r_state;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_bridge_reset_seq.sv
// Self-checking bench for bridge_reset_seq: bring-up table, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_bridge_reset_seq;

  localparam int NL   = 4;
  localparam int HOLD = 8;
  localparam int PRST = 4;
  localparam int LT   = 64;
  localparam int RL   = 3;

  logic          clk_50mhz = 1'b0;
  logic          rst_50mhz;
  logic          soft_reset_req;
  logic          i2c_init_busy;
  logic          phy_pll_locked;
  logic [NL-1:0] phy_tx_ready;
  logic [NL-1:0] phy_rx_ready;
  logic          phy_reset, soc_reset, mac_reset, seq_ready, seq_error;
  logic [2:0]    seq_state;
  logic [NL-1:0] link_up;
  logic [1:0]    retry_count;

  bridge_reset_seq #(
    .NUM_LANES(NL), .HOLD_CYCLES(HOLD), .PHY_RST_CYCLES(PRST),
    .LOCK_TIMEOUT(LT), .RETRY_LIMIT(RL)
  ) dut (
    .clk_50mhz      (clk_50mhz),
    .rst_50mhz      (rst_50mhz),
    .soft_reset_req (soft_reset_req),
    .i2c_init_busy  (i2c_init_busy),
    .phy_pll_locked (phy_pll_locked),
    .phy_tx_ready   (phy_tx_ready),
    .phy_rx_ready   (phy_rx_ready),
    .phy_reset      (phy_reset),
    .soc_reset      (soc_reset),
    .mac_reset      (mac_reset),
    .seq_ready      (seq_ready),
    .seq_error      (seq_error),
    .seq_state      (seq_state),
    .link_up        (link_up),
    .retry_count    (retry_count)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: state code, cycles spent in that state, retry count,
  // and the last two input samples (what the 2-flop synchronizer exposes).
  int m_state, m_dwell, m_retry;
  logic [2*NL:0] m_d1, m_d2;

  task automatic model_reset();
    m_state = 0; m_dwell = 0; m_retry = 0; m_d1 = '0; m_d2 = '0;
  endtask

  task automatic model_step();
    logic pll_s;
    logic [NL-1:0] tx_s;
    int nxt;
    bit to;
    pll_s = m_d2[2*NL];
    tx_s  = m_d2[2*NL-1:NL];
    nxt   = m_state;
    to    = 0;
    if (soft_reset_req) begin
      nxt = 0;
      m_retry = 0;
    end else begin
      case (m_state)
        0: if (m_dwell == HOLD - 1) nxt = 1;
        1: if (!i2c_init_busy) nxt = 2;
        2: if (m_dwell == PRST - 1) nxt = 3;
        3: if (pll_s) nxt = 4; else if (m_dwell == LT - 1) to = 1;
        4: if (!pll_s) nxt = 2; else if (tx_s == {NL{1'b1}}) nxt = 5;
           else if (m_dwell == LT - 1) to = 1;
        5: if (!pll_s) nxt = 2;
        default: ;
      endcase
    end
    if (to) begin
      m_retry = (m_retry < 3) ? m_retry + 1 : 3;
      nxt = (m_retry == RL) ? 6 : 2;
    end
    m_dwell = (soft_reset_req || nxt != m_state) ? 0 : m_dwell + 1;
    m_state = nxt;
    m_d2 = m_d1;
    m_d1 = {phy_pll_locked, phy_tx_ready, phy_rx_ready};
  endtask

  function automatic logic [13:0] model_vec();
    logic phy, soc, mac, rdy, err;
    phy = (m_state inside {0, 1, 2, 6});
    soc = (m_state == 0);
    mac = (m_state != 5);
    rdy = (m_state == 5);
    err = (m_state == 6);
    return {phy, soc, mac, rdy, err, 3'(m_state), 2'(m_retry), m_d2[NL-1:0]};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {phy_reset, soc_reset, mac_reset, seq_ready, seq_error,
            seq_state, retry_count, link_up};
  endfunction

  // {state, phy, soc, mac, ready, error, retry}
  function automatic logic [9:0] st_vec();
    return {seq_state, phy_reset, soc_reset, mac_reset, seq_ready, seq_error, retry_count};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    cyc++;
    check($sformatf("model_cyc%0d", cyc), dut_vec(), model_vec());
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst_50mhz = 1'b1;
    #1;
    model_reset();
    cyc = 0;
    check("async_reset", dut_vec(), {5'b11100, 3'd0, 2'd0, 4'h0});
    @(negedge clk_50mhz);
    rst_50mhz = 1'b0;
  endtask

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       phy, soc, mac, rdy;
    logic [3:0] link;
  } vec_t;

  vec_t bring_up[9];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r, bad;
    soft_reset_req = 1'b0;
    i2c_init_busy  = 1'b0;
    phy_pll_locked = 1'b1;
    phy_tx_ready   = 4'hF;
    phy_rx_ready   = 4'hF;
    rst_50mhz      = 1'b1;

    // Clean bring-up checkpoints (cycles counted from reset release).
    bring_up[0] = '{1,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    bring_up[1] = '{2,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF};
    bring_up[2] = '{7,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF};
    bring_up[3] = '{8,  3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    bring_up[4] = '{9,  3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    bring_up[5] = '{12, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    bring_up[6] = '{13, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
    bring_up[7] = '{14, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
    bring_up[8] = '{15, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_to(bring_up[i].cyc);
      check($sformatf("bringup_cyc%0d", bring_up[i].cyc),
            {seq_state, phy_reset, soc_reset, mac_reset, seq_ready, link_up},
            {bring_up[i].st, bring_up[i].phy, bring_up[i].soc, bring_up[i].mac,
             bring_up[i].rdy, bring_up[i].link});
    end

    // I2C gating, then lock timeout into FAIL (async reset taken from RUN).
    i2c_init_busy  = 1'b1;
    phy_pll_locked = 1'b0;
    do_reset();
    run_to(8);
    check("i2c_enter", seq_state, 3'd1);
    bad = 0;
    repeat (100) begin
      tick();
      if (seq_state !== 3'd1 || phy_reset !== 1'b1) bad++;
    end
    check("i2c_gate_held", bad, 0);
    i2c_init_busy = 1'b0;
    tick();
    check("phy_rst_after_busy", {seq_state, phy_reset}, {3'd2, 1'b1});
    run_to(113); check("lock_win1_open",  st_vec(), {3'd3, 5'b00100, 2'd0});
    run_to(176); check("lock_win1_last",  st_vec(), {3'd3, 5'b00100, 2'd0});
    run_to(177); check("lock_timeout1",   st_vec(), {3'd2, 5'b10100, 2'd1});
    run_to(181); check("lock_win2_open",  st_vec(), {3'd3, 5'b00100, 2'd1});
    run_to(244); check("lock_win2_last",  st_vec(), {3'd3, 5'b00100, 2'd1});
    run_to(245); check("lock_timeout2",   st_vec(), {3'd2, 5'b10100, 2'd2});
    run_to(312); check("lock_win3_last",  st_vec(), {3'd3, 5'b00100, 2'd2});
    run_to(313); check("enter_fail",      st_vec(), {3'd6, 5'b10101, 2'd3});
    run_to(330); check("fail_terminal",   st_vec(), {3'd6, 5'b10101, 2'd3});

    // Soft reset out of FAIL, then partial link that times out and recovers.
    phy_pll_locked = 1'b1;
    phy_tx_ready   = 4'h7;
    phy_rx_ready   = 4'h5;
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    s = cyc;
    check("soft_reset", {seq_state, phy_reset, soc_reset, mac_reset, retry_count},
          {3'd0, 3'b111, 2'd0});
    run_to(s + 7);   check("soft_hold_last", seq_state, 3'd0);
    run_to(s + 8);   check("soft_release",   {seq_state, soc_reset}, {3'd1, 1'b0});
    run_to(s + 14);  check("link_win1_open", st_vec(), {3'd4, 5'b00100, 2'd0});
    run_to(s + 77);  check("link_win1_last", st_vec(), {3'd4, 5'b00100, 2'd0});
    run_to(s + 78);  check("link_timeout",   st_vec(), {3'd2, 5'b10100, 2'd1});
    run_to(s + 83);  check("link_win2_open", st_vec(), {3'd4, 5'b00100, 2'd1});
    check("link_up_rx", link_up, 4'h5);
    run_to(s + 100);
    phy_tx_ready = 4'hF;
    run_to(s + 102); check("lane3_sync_lag", seq_state, 3'd4);
    run_to(s + 103); check("link_run",       st_vec(), {3'd5, 5'b00010, 2'd1});

    // Lock loss in RUN for 10 cycles, relock, retry count untouched.
    run_to(s + 110);
    r = cyc;
    phy_pll_locked = 1'b0;
    run_to(r + 2);  check("lossy_still_run", seq_state, 3'd5);
    run_to(r + 3);  check("lock_loss", {seq_state, mac_reset, seq_ready}, {3'd2, 1'b1, 1'b0});
    run_to(r + 10);
    phy_pll_locked = 1'b1;
    run_to(r + 13); check("relock_wait_link", seq_state, 3'd4);
    run_to(r + 14); check("relock_run", st_vec(), {3'd5, 5'b00010, 2'd1});

    // Randomized traffic against the model, with one mid-run async reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) phy_pll_locked = ~phy_pll_locked;
      if ($urandom_range(0, 29) == 0)
        phy_tx_ready = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 7) == 0) phy_rx_ready = 4'($urandom);
      if ($urandom_range(0, 19) == 0) i2c_init_busy = ~i2c_init_busy;
      soft_reset_req = ($urandom_range(0, 249) == 0);
      if (i == 1500) do_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_reset_seq.md
# bridge_reset_seq

Reset and bring-up sequencer for the DE5 bridge board. It replaces the free-running soft-reset counter with an explicit state machine that orders reset release across the SoC, the 4-lane 10G PHY and the 156 MHz MAC domain. Release follows Si570 I2C init completion, PHY PLL lock and per-lane tx_ready, with timeout and bounded retry. It runs on the 50 MHz management clock and drives the reset inputs of the PHY, the SoC and the MAC reset request.

## Interface
Parameters:
- `NUM_LANES`, 4: number of PHY lanes monitored.
- `HOLD_CYCLES`, 1024: cycles all resets are held after rst_50mhz or soft_reset_req.
- `PHY_RST_CYCLES`, 16: width of each PHY reset pulse.
- `LOCK_TIMEOUT`, 1048576: cycles allowed in each of WAIT_LOCK and WAIT_LINK.
- `RETRY_LIMIT`, 3: number of timeouts tolerated before FAIL.

Ports:
- `clk_50mhz`  in  1  management clock.
- `rst_50mhz`  in  1  reset; asynchronous, active-high.
- `soft_reset_req`  in  1  host soft-reset level from the SoC (clk_50mhz domain).
- `i2c_init_busy`  in  1  Si570 init engine busy (clk_50mhz domain).
- `phy_pll_locked`  in  1  asynchronous; synchronized internally.
- `phy_tx_ready`  in  NUM_LANES  asynchronous; synchronized internally.
- `phy_rx_ready`  in  NUM_LANES  asynchronous; synchronized internally.
- `phy_reset`  out  1  PHY management reset.
- `soc_reset`  out  1  SoC reset; drives the SoC reset_n through an inverter.
- `mac_reset`  out  1  MAC-domain reset request; the 156 MHz side synchronizes it.
- `seq_ready`  out  1  high only in RUN.
- `seq_error`  out  1  high only in FAIL.
- `seq_state`  out  3  current state encoding, for LEDs.
- `link_up`  out  NUM_LANES  synchronized phy_rx_ready.
- `retry_count`  out  2  timeouts since last HOLD, saturating.

## Operation
- State encoding: HOLD=0, WAIT_I2C=1, PHY_RST=2, WAIT_LOCK=3, WAIT_LINK=4, RUN=5, FAIL=6.
- **HOLD**
  - phy_reset=1, soc_reset=1, mac_reset=1.
  - Counter runs 0..HOLD_CYCLES-1, then goes to WAIT_I2C.
- **WAIT_I2C**
  - soc_reset=0; phy_reset and mac_reset stay at 1.
  - Goes to PHY_RST on the first cycle i2c_init_busy=0. This keeps PHY reset until the reference clock is programmed.
- **PHY_RST**
  - phy_reset=1 for PHY_RST_CYCLES, then WAIT_LOCK.
- **WAIT_LOCK**
  - phy_reset=0.
  - Synchronized pll_locked=1 → WAIT_LINK.
  - Counter reaching LOCK_TIMEOUT-1 → timeout.
- **WAIT_LINK**
  - All synchronized tx_ready bits = 1 → RUN.
  - Timeout rule as in WAIT_LOCK.
  - pll_locked falling → PHY_RST, with no retry increment.
- **RUN**
  - mac_reset=0, seq_ready=1.
  - pll_locked falling → PHY_RST (mac_reset=1 again), with no retry increment.
- **Timeout**
  - retry_count+1.
  - If the new value equals RETRY_LIMIT → FAIL, otherwise → PHY_RST.
- **FAIL**
  - Terminal. soc_reset=0 so the host keeps PCIe access; phy_reset=1, mac_reset=1, seq_error=1.
- soft_reset_req=1 in any state → HOLD next cycle; counter and retry_count cleared. HOLD is re-entered and restarts every cycle while the request is held, so release happens HOLD_CYCLES after the request falls.
- Single shared counter, width clog2 of the largest of HOLD_CYCLES, PHY_RST_CYCLES and LOCK_TIMEOUT. It clears on every state change.
- Priority: soft_reset_req > lock loss > completion > timeout. If completion and timeout occur in the same cycle, completion wins.

## Timing
- Asynchronous reset values: state=HOLD, phy_reset=1, soc_reset=1, mac_reset=1, seq_ready=0, seq_error=0, seq_state=0, link_up=0, retry_count=0, counter=0.
- All outputs are registered and decoded from the next-state value, so they change in the same edge as seq_state.
- Synchronizers are 2 flops: an asynchronous input change is visible 2–3 clk_50mhz edges later.
- Minimum path from rst_50mhz deassertion to seq_ready, with i2c_init_busy=0 and all PHY inputs high: HOLD_CYCLES + 1 + PHY_RST_CYCLES + 1 + 1 cycles.
- rst_50mhz asserted mid-sequence: all outputs return to reset values immediately (asynchronously).

## Structure
- Package `bridge_reset_pkg`: state enum and encodings; seq_state width constant.
- Sub-module `sync2`: parameterized-width two-flop synchronizer with asynchronous reset to 0. It is instantiated once for {phy_pll_locked, phy_tx_ready, phy_rx_ready}.

## Test plan
Benches use HOLD_CYCLES=8, PHY_RST_CYCLES=4, LOCK_TIMEOUT=64, RETRY_LIMIT=3.
- **Clean bring-up.** Release rst; i2c_init_busy=0; pll_locked and tx_ready=4'hF held high → soc_reset falls at cycle 8, phy_reset pulse ends at cycle 13, seq_ready=1 by cycle 16, seq_state=5.
- **I2C gating.** i2c_init_busy=1 for 100 cycles → seq_state stays 1 and phy_reset=1 throughout; PHY_RST begins 1 cycle after busy falls.
- **Lock timeout.** pll_locked held 0 → three 64-cycle WAIT_LOCK windows with retry_count=1 then 2 between them; FAIL entered with seq_error=1, phy_reset=1, soc_reset=0.
- **Lock loss in RUN.** Drop pll_locked for 10 cycles → mac_reset=1 and seq_ready=0 within 3 cycles; sequence returns to RUN after relock; retry_count unchanged.
- **Soft reset.** Pulse soft_reset_req for 1 cycle while in FAIL → next cycle seq_state=0, all resets=1, retry_count=0; full bring-up completes.
- **Partial link.** tx_ready=4'h7 → WAIT_LINK times out and retries; setting lane 3 high mid-window → RUN.
